ram_burst_reader: RTL and testbench
===================================

RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 16, giving the data word width.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum cycles to wait for mem_ready after a load.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port cmd_valid, input, 1, client burst request.
REQ-006 The block SHALL have port cmd_ready, output, 1, block accepts a request this cycle.
REQ-007 The block SHALL have port cmd_addr, input, 16, start word address.
REQ-008 The block SHALL have port cmd_len, input, 8, burst length in 4-word quads.
REQ-009 The block SHALL have port mem_load, output, 1, load strobe to the latency RAM.
REQ-010 The block SHALL have port mem_save, output, 1, save strobe, constant 0.
REQ-011 The block SHALL have port mem_addr, output, 16, RAM quad address.
REQ-012 The block SHALL have port mem_ready, input, 1, RAM data-valid flag.
REQ-013 The block SHALL have ports mem_rdata0..mem_rdata3, input, BIT_WIDTH each, RAM words at addr+0..+3.
REQ-014 The block SHALL have port out_valid, output, 1, stream word valid.
REQ-015 The block SHALL have port out_ready, input, 1, stream consumer ready.
REQ-016 The block SHALL have port out_data, output, BIT_WIDTH, stream word.
REQ-017 The block SHALL have port out_last, output, 1, final word of the burst.
REQ-018 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-019 The block SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-020 The block SHALL implement FSM states IDLE, REQ, WAIT and DRAIN.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a posedge with cmd_valid && cmd_ready, latching addr, len and clearing err.
REQ-022 Accept with cmd_len==0 SHALL perform no RAM access and no output, and the FSM SHALL remain in IDLE.
REQ-023 Accept with cmd_len>0 SHALL go to REQ.
REQ-024 In REQ, mem_load SHALL be 1 for exactly one cycle with mem_addr = current quad address, then the FSM SHALL go to WAIT.
REQ-025 mem_load SHALL be 0 in all states other than REQ.
REQ-026 In WAIT, the block SHALL capture mem_rdata0..3 into a 4-word buffer and go to DRAIN on the first posedge where mem_ready==1'b1; X/Z on mem_ready SHALL count as not-ready.
REQ-027 The nominal RAM response is mem_ready high 2 posedges after the load edge; the block SHALL NOT depend on that exact latency.
REQ-028 In WAIT, a wait counter SHALL increment each cycle; on reaching TIMEOUT without mem_ready, the block SHALL set err=1, discard the burst and go to IDLE with no output.
REQ-029 In DRAIN, out_valid SHALL be 1 with out_data = buffer word i, i = 0,1,2,3 in order; i SHALL advance only on out_valid && out_ready.
REQ-030 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-031 out_last SHALL be 1 only on word 3 of the final quad.
REQ-032 After word 3 handshakes: if quads remain, the quad address SHALL increase by 4 modulo 2^16 (0xFFFC -> 0x0000) and the FSM SHALL go to REQ; otherwise it SHALL go to IDLE.
REQ-033 At most one load SHALL be outstanding; no load SHALL be issued during DRAIN.
REQ-034 cmd_valid outside IDLE SHALL be ignored, and no command state SHALL change.
REQ-035 mem_ready pulses arriving outside WAIT SHALL be ignored.
REQ-036 Burst throughput SHALL be at most 1 word per cycle; minimum quad period is 1 REQ + wait cycles + 4 DRAIN cycles.

Reset
REQ-037 rst low SHALL asynchronously force the FSM to IDLE.
REQ-038 rst low SHALL asynchronously force mem_load=0, mem_save=0, mem_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, err=0 and cmd_ready=0.
REQ-039 cmd_ready SHALL go to 1 on the first posedge after rst rises.
REQ-040 Reset mid-burst SHALL abandon the burst with no further output.

Verification
REQ-041 The bench SHALL cover: addr=0x0010, len=1, RAM latency 2, out_ready=1 -> one load at 0x0010, 4 words on consecutive cycles, out_last on the 4th, cmd_ready high the next cycle.
REQ-042 The bench SHALL cover: addr=0xFFFC, len=2 -> loads at 0xFFFC then 0x0000, 8 words, out_last only on the 8th.
REQ-043 The bench SHALL cover: out_ready toggling 1,0,0,1... -> each word held stable while stalled, no word lost or duplicated.
REQ-044 The bench SHALL cover: mem_ready never asserted -> err=1 after 15 WAIT cycles, FSM in IDLE, out_valid never 1; the next accepted command clears err.
REQ-045 The bench SHALL cover: len=0 -> no mem_load, no out_valid, cmd_ready stays 1.
REQ-046 The bench SHALL cover: rst low during DRAIN at word 2 -> out_valid=0 immediately, busy=0, and a new command works normally after rst rises.

Source files
------------

// File: rtl/ram_burst_reader.sv
// Burst reader: fetches quads from a variable-latency RAM and streams them
// out one word per handshake, with a sticky timeout error.
module ram_burst_reader #(
    parameter int BIT_WIDTH = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [15:0]          cmd_addr,
    input  logic [7:0]           cmd_len,
    output logic                 mem_load,
    output logic                 mem_save,
    output logic [15:0]          mem_addr,
    input  logic                 mem_ready,
    input  logic [BIT_WIDTH-1:0] mem_rdata0,
    input  logic [BIT_WIDTH-1:0] mem_rdata1,
    input  logic [BIT_WIDTH-1:0] mem_rdata2,
    input  logic [BIT_WIDTH-1:0] mem_rdata3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]           state_reg, state_next;
    logic [15:0]          quad_addr_reg;
    logic [7:0]           quads_left_reg;
    logic [1:0]           word_idx_reg;
    logic [CW-1:0]        wait_cnt_reg;
    logic                 err_reg;
    logic                 cmd_ready_reg;
    logic [BIT_WIDTH-1:0] rdata_word [4];
    logic [BIT_WIDTH-1:0] buf_word [4];

    logic accept, timed_out, out_fire, quad_done, capture;

    assign accept    = cmd_valid && cmd_ready_reg && (state_reg == ST_IDLE);
    assign timed_out = (wait_cnt_reg == CW'(TIMEOUT - 1));
    assign out_fire  = (state_reg == ST_DRAIN) && out_ready;
    assign quad_done = out_fire && (word_idx_reg == 2'd3);
    // An X/Z on mem_ready falls to the not-ready branch in simulation.
    assign capture   = (state_reg == ST_WAIT) && (mem_ready == 1'b1);

    assign rdata_word[0] = mem_rdata0;
    assign rdata_word[1] = mem_rdata1;
    assign rdata_word[2] = mem_rdata2;
    assign rdata_word[3] = mem_rdata3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_buf
            logic [BIT_WIDTH-1:0] word_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    word_reg <= '0;
                end else if (capture) begin
                    word_reg <= rdata_word[gi];
                end
            end
            assign buf_word[gi] = word_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept && (cmd_len != 8'd0)) state_next = ST_REQ;
            ST_REQ:   state_next = ST_WAIT;
            ST_WAIT: begin
                if (capture)        state_next = ST_DRAIN;
                else if (timed_out) state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (quad_done) state_next = (quads_left_reg == 8'd1) ? ST_IDLE : ST_REQ;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // cmd_ready is registered so it only rises on the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cmd_ready_reg  <= 1'b0;
            quad_addr_reg  <= '0;
            quads_left_reg <= '0;
            word_idx_reg   <= '0;
            wait_cnt_reg   <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= (state_next == ST_IDLE);
            if (accept) begin
                quad_addr_reg  <= cmd_addr;
                quads_left_reg <= cmd_len;
                word_idx_reg   <= '0;
                err_reg        <= 1'b0;
            end
            if (state_reg == ST_REQ) begin
                wait_cnt_reg <= '0;
            end
            if ((state_reg == ST_WAIT) && !capture) begin
                if (timed_out) err_reg <= 1'b1;
                else           wait_cnt_reg <= wait_cnt_reg + CW'(1);
            end
            if (out_fire) begin
                word_idx_reg <= word_idx_reg + 2'd1;
            end
            if (quad_done && (quads_left_reg != 8'd1)) begin
                quads_left_reg <= quads_left_reg - 8'd1;
                quad_addr_reg  <= quad_addr_reg + 16'd4;
            end
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign mem_load  = (state_reg == ST_REQ);
    assign mem_save  = 1'b0;
    assign mem_addr  = quad_addr_reg;
    assign out_valid = (state_reg == ST_DRAIN);
    assign out_data  = out_valid ? buf_word[word_idx_reg] : '0;
    assign out_last  = out_valid && (word_idx_reg == 2'd3) && (quads_left_reg == 8'd1);
    assign busy      = (state_reg != ST_IDLE);
    assign err       = err_reg;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader with a variable-latency RAM model.
module tb_ram_burst_reader;

    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [15:0]   cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic          mem_load, mem_save;
    logic [15:0]   mem_addr;
    logic          mem_ready;
    logic [BW-1:0] mem_rdata0, mem_rdata1, mem_rdata2, mem_rdata3;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_data;
    logic          out_last, busy, err;

    ram_burst_reader #(.BIT_WIDTH(BW), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .mem_load(mem_load), .mem_save(mem_save), .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1),
        .mem_rdata2(mem_rdata2), .mem_rdata3(mem_rdata3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int loads_seen = 0;
    int words_seen = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;
    exp_t        exp_q[$];
    logic [15:0] load_q[$];

    function automatic logic [15:0] word_fn(input logic [15:0] a);
        return (a * 16'd3) ^ 16'hC35A;
    endfunction

    // RAM model: mem_ready rises ram_lat posedges after the load edge.
    int          ram_lat = 2;
    bit          ram_never = 1'b0;
    logic        ram_pend;
    int          ram_cnt;
    logic [15:0] ram_addr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_pend <= 1'b0;
            ram_cnt  <= 0;
            ram_addr <= '0;
        end else if (mem_load && !ram_never) begin
            ram_pend <= 1'b1;
            ram_cnt  <= ram_lat - 1;
            ram_addr <= mem_addr;
        end else if (ram_pend) begin
            if (ram_cnt == 0) ram_pend <= 1'b0;
            else              ram_cnt  <= ram_cnt - 1;
        end
    end

    assign mem_ready  = ram_pend && (ram_cnt == 0);
    assign mem_rdata0 = mem_ready ? word_fn(ram_addr)          : 16'hDEAD;
    assign mem_rdata1 = mem_ready ? word_fn(ram_addr + 16'd1)  : 16'hDEAD;
    assign mem_rdata2 = mem_ready ? word_fn(ram_addr + 16'd2)  : 16'hDEAD;
    assign mem_rdata3 = mem_ready ? word_fn(ram_addr + 16'd3)  : 16'hDEAD;

    // Output/load monitor: compares against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_load) begin
                loads_seen++;
                tests_run++;
                if (load_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_load: mem_addr=%h with no load expected", mem_addr);
                end else begin
                    logic [15:0] ea;
                    ea = load_q.pop_front();
                    if (mem_addr !== ea || mem_save !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL load_addr: mem_addr=%h mem_save=%b, expected %h/0", mem_addr, mem_save, ea);
                    end else begin
                        $display("[TB] load addr=%h", mem_addr);
                    end
                end
            end
            if (out_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_word: data=%h last=%b with empty scoreboard", out_data, out_last);
                end else begin
                    if (out_data !== exp_q[0].data || out_last !== exp_q[0].last) begin
                        tests_failed++;
                        $display("FAIL stream_word: data=%h last=%b, expected %h/%b",
                                 out_data, out_last, exp_q[0].data, exp_q[0].last);
                    end
                    if (out_ready) begin
                        $display("[TB] word data=%h last=%b", out_data, out_last);
                        void'(exp_q.pop_front());
                        words_seen++;
                    end
                end
            end
        end
    end

    task automatic issue_cmd(input logic [15:0] addr, input int len, input bit no_data);
        int n;
        for (int q = 0; q < len; q++) begin
            logic [15:0] qa;
            qa = addr + 16'(4 * q);
            load_q.push_back(qa);
            if (!no_data) begin
                for (int k = 0; k < 4; k++) begin
                    exp_t e;
                    e.data = word_fn(qa + 16'(k));
                    e.last = (q == len - 1) && (k == 3);
                    exp_q.push_back(e);
                end
            end
        end
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!cmd_ready) begin
            tests_failed++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b, required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        $display("[TB] cmd addr=%h len=%0d", addr, len);
    endtask

    task automatic wait_idle(input int bound, input bit stall, output int wait_cycles, output int cyc);
        int k;
        k = 0;
        wait_cycles = 0;
        for (cyc = 0; cyc < bound; cyc++) begin
            if (!busy) break;
            if (!mem_load && !out_valid) wait_cycles++;
            @(posedge clk);
            #1;
            if (stall) out_ready = (k % 3 == 0);
            k++;
        end
        out_ready = 1'b1;
        tests_run++;
        if (busy) begin
            tests_failed++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, bound);
        end
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (exp_q.size() != 0 || load_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_leftover: %0d words and %0d loads outstanding, required 0/0",
                     name, exp_q.size(), load_q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({cmd_ready, busy, err, mem_load, mem_save, out_valid, out_last} !== 7'b0 ||
            mem_addr !== 16'h0 || out_data !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: rdy=%b busy=%b err=%b load=%b save=%b valid=%b last=%b addr=%h data=%h, required all 0",
                     cmd_ready, busy, err, mem_load, mem_save, out_valid, out_last, mem_addr, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_ready: cmd_ready=%b before first edge, required 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_first_edge_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        int wc, cyc, l0, w0;
        l0 = loads_seen;
        w0 = words_seen;
        ram_lat = 2;
        issue_cmd(16'h0010, 1, 1'b0);
        wait_idle(100, 1'b0, wc, cyc);
        tests_run++;
        if (cyc !== 7 || wc !== 2) begin
            tests_failed++;
            $display("FAIL basic_timing: burst took %0d cycles with %0d wait, required 7 and 2", cyc, wc);
        end
        tests_run++;
        if (loads_seen - l0 !== 1 || words_seen - w0 !== 4 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_counts: loads=%0d words=%0d cmd_ready=%b, required 1/4/1",
                     loads_seen - l0, words_seen - w0, cmd_ready);
        end
        check_drained("basic");
    endtask

    task automatic test_wrap();
        int wc, cyc, l0, w0;
        l0 = loads_seen;
        w0 = words_seen;
        issue_cmd(16'hFFFC, 2, 1'b0);
        wait_idle(200, 1'b0, wc, cyc);
        tests_run++;
        if (loads_seen - l0 !== 2 || words_seen - w0 !== 8) begin
            tests_failed++;
            $display("FAIL wrap_counts: loads=%0d words=%0d, required 2/8", loads_seen - l0, words_seen - w0);
        end
        check_drained("wrap");
    endtask

    task automatic test_stall();
        int wc, cyc, w0;
        w0 = words_seen;
        ram_lat = 5;
        issue_cmd(16'h1230, 3, 1'b0);
        wait_idle(400, 1'b1, wc, cyc);
        tests_run++;
        if (words_seen - w0 !== 12) begin
            tests_failed++;
            $display("FAIL stall_words: %0d words delivered, required 12", words_seen - w0);
        end
        ram_lat = 2;
        check_drained("stall");
    endtask

    task automatic test_timeout();
        int wc, cyc;
        ram_never = 1'b1;
        issue_cmd(16'h0100, 1, 1'b1);
        wait_idle(100, 1'b0, wc, cyc);
        tests_run++;
        if (wc !== 15 || err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout: wait=%0d err=%b busy=%b rdy=%b, required 15/1/0/1", wc, err, busy, cmd_ready);
        end
        ram_never = 1'b0;
        issue_cmd(16'h0110, 1, 1'b0);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_err_clear: err=%b after accept, required 0", err);
        end
        wait_idle(100, 1'b0, wc, cyc);
        check_drained("timeout");
    endtask

    task automatic test_len_zero();
        int l0;
        l0 = loads_seen;
        issue_cmd(16'h0400, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL len0_idle: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
            end
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (loads_seen !== l0) begin
            tests_failed++;
            $display("FAIL len0_loads: %0d loads, required 0", loads_seen - l0);
        end
        check_drained("len0");
    endtask

    task automatic test_reset_mid();
        int wc, cyc, w0, n;
        w0 = words_seen;
        issue_cmd(16'h0200, 2, 1'b0);
        n = 0;
        while (!(out_valid && words_seen == w0 + 2) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (!(out_valid && words_seen == w0 + 2)) begin
            tests_failed++;
            $display("FAIL reset_mid_reach: word 2 not presented (valid=%b words=%0d), required 1/2",
                     out_valid, words_seen - w0);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0 || mem_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: valid=%b busy=%b data=%h load=%b, required 0/0/0000/0",
                     out_valid, busy, out_data, mem_load);
        end
        exp_q.delete();
        load_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        w0 = words_seen;
        issue_cmd(16'h0300, 1, 1'b0);
        wait_idle(100, 1'b0, wc, cyc);
        tests_run++;
        if (words_seen - w0 !== 4) begin
            tests_failed++;
            $display("FAIL reset_mid_recover: %0d words, required 4", words_seen - w0);
        end
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_timeout();
        test_len_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
